as_gpio_ctrl: RTL

Memory-mapped GPIO peripheral sitting directly downstream of the RV64I core's data-memory bus decoder. It converts core store/load accesses in the GPIO window into registered pin values on the bidirectional gpio_io bus. It pulses cs_o for each accepted output-data write; this is the strobe the top-level bench samples to check program results. It also synchronises pin inputs so software can read them back.

---
 rtl/as_pack.sv | 16 +
 rtl/as_gpio_sync.sv | 23 ++
 rtl/as_gpio_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/as_pack.sv
// Shared constants for the as_* core slice: GPIO geometry and register map.
package as_pack;

  localparam int nr_gpios        = 8;
  localparam int gpio_addr_width = 8;

  typedef enum logic [1:0] {
    GPIO_DOUT = 2'd0,
    GPIO_DIR  = 2'd1,
    GPIO_DIN  = 2'd2,
    GPIO_IRQ  = 2'd3
  } gpio_reg_e;

  localparam logic [nr_gpios-1:0] GPIO_DIR_RST = '1;

endpackage

// File: rtl/as_gpio_sync.sv
// Two-flop synchroniser for asynchronous pin inputs, async active-high reset.
module as_gpio_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta <= '0;
      q_o  <= '0;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/as_gpio_ctrl.sv
// Memory-mapped GPIO block: DATA_OUT/DIR/DATA_IN registers, cs_o strobe on output writes.
// Optional pin-edge interrupt status (IRQ_STAT, irq_o) enabled by AS_GPIO_IRQ_EN.
module as_gpio_ctrl
  import as_pack::*;
#(
  parameter int NR_GPIOS = nr_gpios,
  parameter int ADDR_W   = gpio_addr_width,
  parameter int DATA_W   = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sel_i,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o,
  inout  wire  [NR_GPIOS-1:0] gpio_io,
  output logic [ADDR_W-1:0]   gpioAddr_o,
  output logic                cs_o
`ifdef AS_GPIO_IRQ_EN
  ,
  output logic                irq_o
`endif
);

  logic [NR_GPIOS-1:0] dout, dir, din, rd_val;
  gpio_reg_e           reg_sel;
  logic                wr_en, rd_en;

  assign reg_sel = gpio_reg_e'(addr_i[4:3]);
  assign wr_en   = sel_i & we_i;
  assign rd_en   = sel_i & re_i;

  // Only the register-select bits and the pin-wide slice of the data bus matter.
  logic unused_bits;
  assign unused_bits = ^{wdata_i[DATA_W-1:NR_GPIOS], addr_i[ADDR_W-1:5], addr_i[2:0]};

  for (genvar i = 0; i < NR_GPIOS; i++) begin : g_pin
    assign gpio_io[i] = dir[i] ? dout[i] : 1'bz;
  end

  as_gpio_sync #(.WIDTH(NR_GPIOS)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (gpio_io),
    .q_o   (din)
  );

`ifdef AS_GPIO_IRQ_EN
  logic [NR_GPIOS-1:0] din_q, irq_stat, irq_clr, irq_rise;

  assign irq_clr  = (wr_en && reg_sel == GPIO_IRQ) ? wdata_i[NR_GPIOS-1:0] : '0;
  assign irq_rise = din & ~din_q & ~dir;

  // A rising edge in the same cycle as a clear wins, so no event is lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      din_q    <= '0;
      irq_stat <= '0;
      irq_o    <= 1'b0;
    end else begin
      din_q    <= din;
      irq_stat <= (irq_stat & ~irq_clr) | irq_rise;
      irq_o    <= |irq_stat;
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      GPIO_DOUT: rd_val = dout;
      GPIO_DIR:  rd_val = dir;
      GPIO_DIN:  rd_val = din;
`ifdef AS_GPIO_IRQ_EN
      GPIO_IRQ:  rd_val = irq_stat;
`else
      GPIO_IRQ:  rd_val = '0;
`endif
      default:   rd_val = '0;
    endcase
  end

  // Read and write share the edge; the read samples the pre-write register value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dout       <= '0;
      dir        <= {NR_GPIOS{GPIO_DIR_RST[0]}};
      rdata_o    <= '0;
      gpioAddr_o <= '0;
      cs_o       <= 1'b0;
    end else begin
      cs_o <= 1'b0;
      if (wr_en) begin
        case (reg_sel)
          GPIO_DOUT: begin
            dout       <= wdata_i[NR_GPIOS-1:0];
            gpioAddr_o <= addr_i;
            cs_o       <= 1'b1;
          end
          GPIO_DIR: dir <= wdata_i[NR_GPIOS-1:0];
          default: ;
        endcase
      end
      if (rd_en)
        rdata_o <= {{(DATA_W-NR_GPIOS){1'b0}}, rd_val};
    end
  end

endmodule
